// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write bus driven by the boot loader.
// The master side issues one-cycle write strobes with address and data.
interface uart_imem_loader_if #(
   parameter int AW = 10
);
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;

   modport master (
      output imem_we,
      output imem_addr,
      output imem_wdata
   );

   modport slave (
      input imem_we,
      input imem_addr,
      input imem_wdata
   );
endinterface

// File: rtl/uart_imem_loader.sv
// UART boot loader: writes a framed image into imem, then releases core_rst.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_imem_loader #(
   parameter int         CLK_FREQ_HZ = 50_000_000,
   parameter int         BAUD        = 115_200,
   parameter int         IMEM_DEPTH  = 1024,
   parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx,
   uart_imem_loader_if.master imem,
   output logic               core_rst,
   output logic               load_done,
   output logic               load_error
);
   localparam int AW  = $clog2(IMEM_DEPTH);
   localparam int CPB = CLK_FREQ_HZ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);

   typedef enum logic [1:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA,
`ifdef LOADER_CHECKSUM_EN
      S_CHK,
`endif
      S_DONE, S_ERROR
   } ld_state_t;

   logic          r_rx_s1;
   logic          r_rx_s2;
   logic          r_rx_prev;
   rx_state_t     r_rx_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_byte_valid;
   logic          r_frame_err;

   ld_state_t     r_state;
   logic [7:0]    r_len_lo;
   logic [15:0]   r_left;
   logic [1:0]    r_bcnt;
   logic [23:0]   r_asm;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic          r_we;
   logic          r_core_rst;
   logic          r_done;
   logic          r_err;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]    r_xor;
`endif

   logic [15:0]   w_len;
   logic          w_len_big;

   assign w_len     = {r_shift, r_len_lo};
   assign w_len_big = int'(w_len) > IMEM_DEPTH;

   // r_shift holds the received byte while r_byte_valid is high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1      <= 1'b1;
         r_rx_s2      <= 1'b1;
         r_rx_prev    <= 1'b1;
         r_rx_state   <= RX_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_rx_s1      <= rx;
         r_rx_s2      <= r_rx_s1;
         r_rx_prev    <= r_rx_s2;
         r_byte_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         unique case (r_rx_state)
            RX_IDLE: begin
               if (r_rx_prev && !r_rx_s2) begin
                  r_cnt      <= '0;
                  r_rx_state <= RX_START;
               end
            end
            RX_START: begin
               if (r_cnt == HALF_M1) begin
                  r_cnt      <= '0;
                  r_bit      <= '0;
                  r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_DATA: begin
               if (r_cnt == CPB_M1) begin
                  r_cnt   <= '0;
                  r_shift <= {r_rx_s2, r_shift[7:1]};
                  r_bit   <= r_bit + 1'b1;
                  if (r_bit == 3'd7) r_rx_state <= RX_STOP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (r_cnt == CPB_M1) begin
                  r_cnt        <= '0;
                  r_rx_state   <= RX_IDLE;
                  r_byte_valid <= r_rx_s2;
                  r_frame_err  <= !r_rx_s2;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_rx_state <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_WAIT_SYNC;
         r_len_lo   <= '0;
         r_left     <= '0;
         r_bcnt     <= '0;
         r_asm      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_core_rst <= 1'b1;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         r_xor      <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         unique case (r_state)
            S_WAIT_SYNC: begin
               if (r_byte_valid && r_shift == SYNC_BYTE)
                  r_state <= S_LEN_LO;
            end
            S_LEN_LO: begin
               if (r_frame_err) begin
                  r_state <= S_ERROR;
                  r_err   <= 1'b1;
               end else if (r_byte_valid) begin
                  r_len_lo <= r_shift;
                  r_state  <= S_LEN_HI;
               end
            end
            S_LEN_HI: begin
               if (r_frame_err || (r_byte_valid && w_len_big)) begin
                  r_state <= S_ERROR;
                  r_err   <= 1'b1;
               end else if (r_byte_valid && w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                  r_state    <= S_CHK;
`else
                  r_state    <= S_DONE;
                  r_core_rst <= 1'b0;
                  r_done     <= 1'b1;
`endif
               end else if (r_byte_valid) begin
                  r_left  <= w_len;
                  r_bcnt  <= '0;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (r_frame_err) begin
                  r_state <= S_ERROR;
                  r_err   <= 1'b1;
               end else if (r_we) begin
                  // the write has been issued; advance to the next word
                  r_addr <= r_addr + 1'b1;
                  r_left <= r_left - 1'b1;
                  if (r_left == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                     r_state    <= S_CHK;
`else
                     r_state    <= S_DONE;
                     r_core_rst <= 1'b0;
                     r_done     <= 1'b1;
`endif
                  end
               end else if (r_byte_valid) begin
`ifdef LOADER_CHECKSUM_EN
                  r_xor <= r_xor ^ r_shift;
`endif
                  r_bcnt <= r_bcnt + 1'b1;
                  if (r_bcnt == 2'd3) begin
                     r_we    <= 1'b1;
                     r_wdata <= {r_shift, r_asm};
                  end else begin
                     r_asm <= {r_shift, r_asm[23:8]};
                  end
               end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
               if (r_frame_err || (r_byte_valid && r_shift != r_xor)) begin
                  r_state <= S_ERROR;
                  r_err   <= 1'b1;
               end else if (r_byte_valid) begin
                  r_state    <= S_DONE;
                  r_core_rst <= 1'b0;
                  r_done     <= 1'b1;
               end
            end
`endif
            S_DONE:  ;
            S_ERROR: ;
            default: begin
               r_state <= S_ERROR;
               r_err   <= 1'b1;
            end
         endcase
      end
   end

   assign imem.imem_we    = r_we;
   assign imem.imem_addr  = r_addr;
   assign imem.imem_wdata = r_wdata;
   assign core_rst        = r_core_rst;
   assign load_done       = r_done;
   assign load_error      = r_err;
endmodule
